// File: rtl/mpu_pkg.sv
// Shared constants, FSM state type and element-offset helper for the MPU matrix loader.
// Used by mpu_matrix_loader and its testbench; see mpu_elem_index for MPU_LOADER_TRANSPOSE_EN.
package mpu_pkg;

  localparam int N      = 5;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = ELEM_W * N * N;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_t;

  // Bit offset of element (col,row) inside the flattened matrix.
  function automatic int at(input int col, input int row);
    return ELEM_W * (row + N * col);
  endfunction

endpackage

// File: rtl/mpu_elem_index.sv
// Maps the running element count k to its flat storage index in the matrix.
// With MPU_LOADER_TRANSPOSE_EN defined the stream is stored transposed.
module mpu_elem_index #(
  parameter int N = mpu_pkg::N
) (
  input  logic [$clog2(N*N+1)-1:0] k,
  output logic [$clog2(N*N+1)-1:0] idx
);

  localparam int CW = $clog2(N*N+1);

`ifdef MPU_LOADER_TRANSPOSE_EN
  // Element k lands at column (k mod N), row (k / N).
  always_comb begin
    idx = CW'((int'(k) % N) * N + int'(k) / N);
  end
`else
  always_comb begin
    idx = k;
  end
`endif

endmodule

// File: rtl/mpu_matrix_loader.sv
// Streams N*N signed elements into a flattened matrix and holds it until acknowledged.
// Optional build macro MPU_LOADER_TRANSPOSE_EN loads the transpose (handled in mpu_elem_index).
module mpu_matrix_loader
  import mpu_pkg::*;
#(
  parameter int N      = 5,
  parameter int ELEM_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ELEM_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ELEM_W*N*N-1:0]       matrix,
  output logic                        matrix_valid,
  input  logic                        matrix_ack,
  output logic                        busy,
  output logic [$clog2(N*N+1)-1:0]    count
);

  localparam int            CW   = $clog2(N*N+1);
  localparam logic [CW-1:0] LAST = CW'(N*N - 1);

  state_t        state;
  state_t        state_next;
  logic          clear;
  logic          xfer;
  logic [CW-1:0] idx;

  mpu_elem_index #(
    .N(N)
  ) u_elem_index (
    .k  (count),
    .idx(idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start always wins over a transfer in LOAD, so a restart never swallows an element.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    matrix_valid = 1'b0;
    busy         = 1'b0;
    clear        = 1'b0;
    xfer         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = !start;
        if (start) begin
          clear = 1'b1;
        end else if (in_valid) begin
          xfer = 1'b1;
          if (count == LAST) begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        matrix_valid = 1'b1;
        if (matrix_ack) begin
          if (start) begin
            state_next = LOAD;
            clear      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count  <= '0;
      matrix <= '0;
    end else if (xfer) begin
      matrix[ELEM_W*idx +: ELEM_W] <= in_data;
      count                        <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: element-grid model plus directed literal checks.
// Define MPU_LOADER_TRANSPOSE_EN for both bench and RTL to check the transposed build.
module tb_mpu_matrix_loader;
  import mpu_pkg::*;

  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_FULL = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [MAT_W-1:0]  matrix;
  logic              matrix_valid;
  logic              matrix_ack;
  logic              busy;
  logic [CW-1:0]     count;

  int n_cmp  = 0;
  int n_fail = 0;

  int          phase = P_IDLE;
  int          m_count = 0;
  logic [7:0]  m_elem [N][N];
  bit          check_en = 1'b0;

  always #5 clk = ~clk;

  mpu_matrix_loader #(
    .N(N),
    .ELEM_W(ELEM_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .matrix      (matrix),
    .matrix_valid(matrix_valid),
    .matrix_ack  (matrix_ack),
    .busy        (busy),
    .count       (count)
  );

  task automatic checkOutput(input string name, input logic [MAT_W-1:0] actual,
                             input logic [MAT_W-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void m_clear();
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++)
        m_elem[c][r] = '0;
  endfunction

  function automatic logic [MAT_W-1:0] m_matrix();
    logic [MAT_W-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++)
        v[at(c, r) +: ELEM_W] = m_elem[c][r];
    return v;
  endfunction

  // Model: the k-th accepted element fills the grid column by column (row by row when transposed).
  always @(posedge clk) begin
    if (!rst_n) begin
      phase    = P_IDLE;
      m_count  = 0;
      m_clear();
      check_en = 1'b1;
    end else if (phase == P_IDLE) begin
      if (start) begin
        phase   = P_LOAD;
        m_count = 0;
        m_clear();
      end
    end else if (phase == P_LOAD) begin
      if (start) begin
        m_count = 0;
        m_clear();
      end else if (in_valid) begin
`ifdef MPU_LOADER_TRANSPOSE_EN
        m_elem[m_count % N][m_count / N] = in_data;
`else
        m_elem[m_count / N][m_count % N] = in_data;
`endif
        m_count++;
        if (m_count == NN) phase = P_FULL;
      end
    end else begin
      if (matrix_ack) begin
        if (start) begin
          phase   = P_LOAD;
          m_count = 0;
          m_clear();
        end else begin
          phase = P_IDLE;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("in_ready", MAT_W'(in_ready), MAT_W'(phase == P_LOAD && !start));
      checkOutput("busy", MAT_W'(busy), MAT_W'(phase == P_LOAD));
      checkOutput("matrix_valid", MAT_W'(matrix_valid), MAT_W'(phase == P_FULL));
      checkOutput("count", MAT_W'(count), MAT_W'(m_count));
      checkOutput("matrix", matrix, m_matrix());
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic [7:0] d, input logic a);
    rst_n      = r;
    start      = s;
    in_valid   = v;
    in_data    = d;
    matrix_ack = a;
    @(posedge clk);
    #1;
  endtask

  int vals[NN];

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; matrix_ack = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("reset_count", MAT_W'(count), MAT_W'(0));
    checkOutput("reset_matrix", matrix, '0);
    checkOutput("reset_in_ready", MAT_W'(in_ready), MAT_W'(0));

    applyStimulus(1, 0, 1, 8'h55, 0);
    applyStimulus(1, 0, 1, 8'h55, 0);
    checkOutput("idle_valid_ignored", MAT_W'(count), MAT_W'(0));

    // Stream 1..25 back to back.
    applyStimulus(1, 1, 0, 8'h00, 0);
    for (int k = 1; k <= NN; k++) applyStimulus(1, 0, 1, 8'(k), 0);
    checkOutput("s1_valid", MAT_W'(matrix_valid), MAT_W'(1));
    checkOutput("s1_count", MAT_W'(count), MAT_W'(25));
    checkOutput("s1_e00", MAT_W'(matrix[at(0, 0) +: 8]), MAT_W'(1));
    checkOutput("s1_e44", MAT_W'(matrix[at(4, 4) +: 8]), MAT_W'(25));
`ifdef MPU_LOADER_TRANSPOSE_EN
    checkOutput("s1_e10", MAT_W'(matrix[at(1, 0) +: 8]), MAT_W'(2));
    checkOutput("s1_e01", MAT_W'(matrix[at(0, 1) +: 8]), MAT_W'(6));
`else
    checkOutput("s1_e01", MAT_W'(matrix[at(0, 1) +: 8]), MAT_W'(2));
    checkOutput("s1_e10", MAT_W'(matrix[at(1, 0) +: 8]), MAT_W'(6));
`endif
    applyStimulus(1, 0, 0, 8'h00, 1);
    checkOutput("s1_ack_idle", MAT_W'(matrix_valid), MAT_W'(0));

    // Sign-extreme values with in_valid toggling.
    for (int i = 0; i < NN; i++) vals[i] = i + 1;
    vals[0] = -1; vals[1] = -128; vals[2] = 127;
    applyStimulus(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < NN; i++) begin
      applyStimulus(1, 0, 0, 8'hAA, 0);
      applyStimulus(1, 0, 1, 8'(vals[i]), 0);
    end
    checkOutput("s2_valid", MAT_W'(matrix_valid), MAT_W'(1));
    checkOutput("s2_k0", MAT_W'(matrix[0 +: 8]), MAT_W'(8'hFF));
`ifdef MPU_LOADER_TRANSPOSE_EN
    checkOutput("s2_k1", MAT_W'(matrix[40 +: 8]), MAT_W'(8'h80));
    checkOutput("s2_k2", MAT_W'(matrix[80 +: 8]), MAT_W'(8'h7F));
`else
    checkOutput("s2_k1", MAT_W'(matrix[8 +: 8]), MAT_W'(8'h80));
    checkOutput("s2_k2", MAT_W'(matrix[16 +: 8]), MAT_W'(8'h7F));
`endif
    applyStimulus(1, 0, 0, 8'h00, 1);

    // Restart mid-load while data is offered.
    applyStimulus(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 8'(100 + i), 0);
    rst_n = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'd99; matrix_ack = 1'b0;
    #2;
    checkOutput("s3_restart_in_ready", MAT_W'(in_ready), MAT_W'(0));
    @(posedge clk);
    #1;
    checkOutput("s3_restart_count", MAT_W'(count), MAT_W'(0));
    checkOutput("s3_restart_matrix", matrix, '0);
    for (int i = 0; i < NN; i++) applyStimulus(1, 0, 1, 8'(200 + i), 0);
    checkOutput("s3_valid", MAT_W'(matrix_valid), MAT_W'(1));

    // FULL: lone start ignored, start with ack reloads.
    applyStimulus(1, 1, 0, 8'h00, 0);
    checkOutput("s4_still_full", MAT_W'(matrix_valid), MAT_W'(1));
    checkOutput("s4_e00_held", MAT_W'(matrix[at(0, 0) +: 8]), MAT_W'(200));
    checkOutput("s4_count_held", MAT_W'(count), MAT_W'(25));
    applyStimulus(1, 1, 0, 8'h00, 1);
    checkOutput("s4_reload_busy", MAT_W'(busy), MAT_W'(1));
    checkOutput("s4_reload_count", MAT_W'(count), MAT_W'(0));
    checkOutput("s4_reload_matrix", matrix, '0);

    // Reset mid-load, then reset while FULL.
    for (int i = 0; i < 17; i++) applyStimulus(1, 0, 1, 8'(i + 30), 0);
    checkOutput("s5_count17", MAT_W'(count), MAT_W'(17));
    applyStimulus(0, 0, 1, 8'h77, 0);
    checkOutput("s5_rst_count", MAT_W'(count), MAT_W'(0));
    checkOutput("s5_rst_matrix", matrix, '0);
    checkOutput("s5_rst_in_ready", MAT_W'(in_ready), MAT_W'(0));
    checkOutput("s5_rst_busy", MAT_W'(busy), MAT_W'(0));
    applyStimulus(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < NN; i++) applyStimulus(1, 0, 1, 8'(i + 60), 0);
    applyStimulus(0, 1, 1, 8'h12, 1);
    checkOutput("s5_full_rst_valid", MAT_W'(matrix_valid), MAT_W'(0));
    checkOutput("s5_full_rst_count", MAT_W'(count), MAT_W'(0));
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
